// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall sequencer: per-stage stall vectors
// and the FSM state encoding shown on the debug LEDs.
package pipeline_ctrl_pkg;

    // Bit order: [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        PCTL_RUN   = 2'd0,
        PCTL_MWAIT = 2'd1,
        PCTL_HALT  = 2'd2,
        PCTL_STEP  = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser plus rising-edge detector; emits a one-cycle pulse
// for each press of an asynchronous button, however long it is held.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    // sync[0..1] are the metastability flops, sync[2] holds the previous sample
    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= 3'b000;
        else     sync <= {sync[1:0], din};
    end

    assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall sequencer: merges load-use stalls, slow-I/O wait states and
// single-step debug into one per-stage hold vector for the 5-stage pipeline.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 2,
    parameter int STEP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_stall_req,
    input  logic                  mem_req,
    input  logic                  mem_slow,
    input  logic                  branch_flag,
    input  logic                  step_mode,
    input  logic                  step_btn,
    output logic [5:0]            stall,
    output logic                  ex_bubble,
    output logic                  wb_bubble,
    output logic                  branch_take,
    output logic                  mem_ack,
    output logic [STEP_CNT_W-1:0] step_cnt,
    output logic [1:0]            state
);

    localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
    localparam logic [STEP_CNT_W-1:0] CNT_ONE = {{(STEP_CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_n;
    logic [3:0]            cnt_q, cnt_n;
    logic                  step_pend_q, step_pend_n;
    logic [STEP_CNT_W-1:0] step_cnt_q;
    logic                  step_inc;
    logic                  step_pulse;
    logic                  slow;
    logic [5:0]            stall_c;
    logic                  ex_bubble_c, wb_bubble_c, mem_ack_c;

    pulse_sync u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (step_btn),
        .pulse (step_pulse)
    );

    assign slow = mem_req & mem_slow;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        stall_c     = STALL_NONE;
        ex_bubble_c = 1'b0;
        wb_bubble_c = 1'b0;
        mem_ack_c   = 1'b0;
        state_n     = state_q;
        cnt_n       = cnt_q;
        step_pend_n = step_pend_q;
        step_inc    = 1'b0;

        case (state_q)
            PCTL_RUN, PCTL_STEP: begin
                if (slow && (MEM_WAIT > 0)) begin
                    stall_c     = STALL_MEM;
                    wb_bubble_c = 1'b1;
                    cnt_n       = WAIT_LOAD;
                    state_n     = PCTL_MWAIT;
                    // A step that lands on a slow access is counted when it acks
                    step_pend_n = (state_q == PCTL_STEP);
                end else begin
                    mem_ack_c = slow;
                    if (state_q == PCTL_RUN && step_mode) begin
                        stall_c = STALL_ALL;
                        state_n = PCTL_HALT;
                    end else if (id_stall_req) begin
                        stall_c     = STALL_ID;
                        ex_bubble_c = 1'b1;
                    end
                    if (state_q == PCTL_STEP) begin
                        state_n  = PCTL_HALT;
                        step_inc = 1'b1;
                    end
                end
            end
            PCTL_MWAIT: begin
                if (cnt_q != 4'd0) begin
                    stall_c     = STALL_MEM;
                    wb_bubble_c = 1'b1;
                    cnt_n       = cnt_q - 4'd1;
                end else begin
                    mem_ack_c   = 1'b1;
                    if (id_stall_req) begin
                        stall_c     = STALL_ID;
                        ex_bubble_c = 1'b1;
                    end
                    state_n     = step_mode ? PCTL_HALT : PCTL_RUN;
                    step_inc    = step_pend_q;
                    step_pend_n = 1'b0;
                end
            end
            PCTL_HALT: begin
                stall_c = STALL_ALL;
                if (!step_mode)      state_n = PCTL_RUN;
                else if (step_pulse) state_n = PCTL_STEP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PCTL_RUN;
            cnt_q       <= 4'd0;
            step_pend_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            step_pend_q <= step_pend_n;
            if (step_inc) step_cnt_q <= step_cnt_q + CNT_ONE;
        end
    end

    // All outputs read zero while reset is held, aborting any wait without an ack
    assign stall       = rst ? STALL_NONE : stall_c;
    assign ex_bubble   = ~rst & ex_bubble_c;
    assign wb_bubble   = ~rst & wb_bubble_c;
    assign mem_ack     = ~rst & mem_ack_c;
    assign branch_take = ~rst & branch_flag & ~stall_c[2];
    assign step_cnt    = rst ? '0 : step_cnt_q;
    assign state       = rst ? 2'b00 : state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance (MEM_WAIT=2) and a
// second instance (MEM_WAIT=0, 4-bit step counter) share the same stimulus.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst, id_stall_req, mem_req, mem_slow, branch_flag, step_mode, step_btn;

    logic [5:0]  stall, b_stall;
    logic        ex_bubble, wb_bubble, branch_take, mem_ack;
    logic        b_ex_bubble, b_wb_bubble, b_branch_take, b_mem_ack;
    logic [15:0] step_cnt;
    logic [3:0]  b_step_cnt;
    logic [1:0]  state, b_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .id_stall_req(id_stall_req), .mem_req(mem_req),
        .mem_slow(mem_slow), .branch_flag(branch_flag), .step_mode(step_mode),
        .step_btn(step_btn), .stall(stall), .ex_bubble(ex_bubble),
        .wb_bubble(wb_bubble), .branch_take(branch_take), .mem_ack(mem_ack),
        .step_cnt(step_cnt), .state(state)
    );

    pipeline_ctrl #(.MEM_WAIT(0), .STEP_CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_stall_req(id_stall_req), .mem_req(mem_req),
        .mem_slow(mem_slow), .branch_flag(branch_flag), .step_mode(step_mode),
        .step_btn(step_btn), .stall(b_stall), .ex_bubble(b_ex_bubble),
        .wb_bubble(b_wb_bubble), .branch_take(b_branch_take), .mem_ack(b_mem_ack),
        .step_cnt(b_step_cnt), .state(b_state)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_stall_req = 1'b0; mem_req = 1'b0; mem_slow = 1'b0;
        branch_flag = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if (stall !== 6'b000000) begin
            $display("FAIL reset_held_stall: got %b want 000000", stall); miscompares++;
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if (stall !== 6'b000000 || state !== 2'd0) begin
            $display("FAIL reset_idle: stall %b state %0d want 000000 / 0", stall, state); miscompares++;
        end
        vectors++;
        if (step_cnt !== 16'd0 || mem_ack !== 1'b0) begin
            $display("FAIL reset_cnt_ack: step_cnt %0d ack %b want 0 / 0", step_cnt, mem_ack); miscompares++;
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        id_stall_req = 1'b1; branch_flag = 1'b1;
        #1;
        vectors++;
        if (stall !== 6'b000111 || ex_bubble !== 1'b1 || branch_take !== 1'b0) begin
            $display("FAIL load_use_stall: stall %b exb %b take %b want 000111 / 1 / 0",
                     stall, ex_bubble, branch_take); miscompares++;
        end
        next_cycle();
        id_stall_req = 1'b0;
        #1;
        vectors++;
        if (stall !== 6'b000000 || ex_bubble !== 1'b0 || branch_take !== 1'b1) begin
            $display("FAIL load_use_release: stall %b exb %b take %b want 000000 / 0 / 1",
                     stall, ex_bubble, branch_take); miscompares++;
        end
        branch_flag = 1'b0;
    endtask

    task automatic test_slow_access();
        next_cycle();
        mem_req = 1'b1; mem_slow = 1'b1;
        #1;
        vectors++;
        if (stall !== 6'b011111 || wb_bubble !== 1'b1 || mem_ack !== 1'b0) begin
            $display("FAIL slow_c0: stall %b wbb %b ack %b want 011111 / 1 / 0",
                     stall, wb_bubble, mem_ack); miscompares++;
        end
        vectors++;
        if (b_stall !== 6'b000000 || b_mem_ack !== 1'b1) begin
            $display("FAIL wait0_c0: stall %b ack %b want 000000 / 1", b_stall, b_mem_ack); miscompares++;
        end
        next_cycle();
        #1;
        vectors++;
        if (stall !== 6'b011111 || mem_ack !== 1'b0 || state !== 2'd1) begin
            $display("FAIL slow_c1: stall %b ack %b state %0d want 011111 / 0 / 1",
                     stall, mem_ack, state); miscompares++;
        end
        next_cycle();
        mem_req = 1'b0; mem_slow = 1'b0;
        #1;
        vectors++;
        if (stall !== 6'b000000 || mem_ack !== 1'b1) begin
            $display("FAIL slow_c2: stall %b ack %b want 000000 / 1", stall, mem_ack); miscompares++;
        end
        next_cycle();
        #1;
        vectors++;
        if (state !== 2'd0 || mem_ack !== 1'b0) begin
            $display("FAIL slow_done: state %0d ack %b want 0 / 0", state, mem_ack); miscompares++;
        end
    endtask

    task automatic test_wait_vs_load_use();
        next_cycle();
        id_stall_req = 1'b1; mem_req = 1'b1; mem_slow = 1'b1;
        #1;
        vectors++;
        if (stall !== 6'b011111 || ex_bubble !== 1'b0 || wb_bubble !== 1'b1) begin
            $display("FAIL wait_vs_lu_c0: stall %b exb %b wbb %b want 011111 / 0 / 1",
                     stall, ex_bubble, wb_bubble); miscompares++;
        end
        next_cycle();
        #1;
        vectors++;
        if (stall !== 6'b011111 || ex_bubble !== 1'b0) begin
            $display("FAIL wait_vs_lu_c1: stall %b exb %b want 011111 / 0", stall, ex_bubble); miscompares++;
        end
        next_cycle();
        mem_req = 1'b0; mem_slow = 1'b0;
        #1;
        vectors++;
        if (stall !== 6'b000111 || ex_bubble !== 1'b1 || mem_ack !== 1'b1) begin
            $display("FAIL wait_vs_lu_c2: stall %b exb %b ack %b want 000111 / 1 / 1",
                     stall, ex_bubble, mem_ack); miscompares++;
        end
        next_cycle();
        id_stall_req = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        mem_req = 1'b1; mem_slow = 1'b1;
        next_cycle();
        mem_req = 1'b0; mem_slow = 1'b0; rst = 1'b1;
        #1;
        vectors++;
        if (stall !== 6'b000000 || mem_ack !== 1'b0) begin
            $display("FAIL rst_in_wait: stall %b ack %b want 000000 / 0", stall, mem_ack); miscompares++;
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if (state !== 2'd0 || mem_ack !== 1'b0 || stall !== 6'b000000) begin
            $display("FAIL rst_after_wait: state %0d ack %b stall %b want 0 / 0 / 000000",
                     state, mem_ack, stall); miscompares++;
        end
    endtask

    task automatic test_step_mode();
        int free_cycles;
        int free_at;
        free_cycles = 0;
        free_at = -1;
        next_cycle();
        step_mode = 1'b1;
        #1;
        vectors++;
        if (stall !== 6'b111111) begin
            $display("FAIL step_enter: stall %b want 111111", stall); miscompares++;
        end
        next_cycle();
        #1;
        vectors++;
        if (state !== 2'd2 || stall !== 6'b111111) begin
            $display("FAIL step_halt: state %0d stall %b want 2 / 111111", state, stall); miscompares++;
        end
        for (int c = 0; c < 25; c++) begin
            next_cycle();
            step_btn = (c < 20);
            #1;
            if (stall == 6'b000000) begin
                free_cycles++;
                free_at = c;
            end
            if (c == 3) begin
                vectors++;
                if (state !== 2'd3) begin
                    $display("FAIL step_state_c3: state %0d want 3", state); miscompares++;
                end
            end
        end
        vectors++;
        if (free_cycles != 1 || free_at != 3) begin
            $display("FAIL step_single: free cycles %0d at %0d want 1 at 3", free_cycles, free_at);
            miscompares++;
        end
        vectors++;
        if (step_cnt !== 16'd1) begin
            $display("FAIL step_cnt: got %0d want 1", step_cnt); miscompares++;
        end
        next_cycle();
        step_mode = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (state !== 2'd0 || stall !== 6'b000000) begin
            $display("FAIL step_exit: state %0d stall %b want 0 / 000000", state, stall); miscompares++;
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] exp_b;
        exp_b = 4'd0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; step_mode = 1'b1;
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            step_btn = 1'b1;
            for (int k = 0; k < 4; k++) begin
                next_cycle();
                step_btn = 1'b0;
            end
            #1;
            exp_b = exp_b + 4'd1;
            vectors++;
            if (b_step_cnt !== exp_b) begin
                $display("FAIL wrap_step%0d: got %0d want %0d", i + 1, b_step_cnt, exp_b); miscompares++;
            end
        end
        vectors++;
        if (step_cnt !== 16'd16) begin
            $display("FAIL wide_cnt_16: got %0d want 16", step_cnt); miscompares++;
        end
        next_cycle();
        step_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_slow_access();
        test_wait_vs_load_use();
        test_reset_mid_wait();
        test_step_mode();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
